reg_file16_read: RTL and testbench

- Eight-entry, 16-bit register file for the 16-bit datapath.
- Datapath registers are loaded through a single write port; this block adds the read side: two registered read ports with a one-cycle read handshake and write-to-read forwarding.
- Sits between instruction decode (supplies read/write addresses) and the ALU operand latches.
- R0 is hardwired to zero.

---
 rtl/reg_file16_read.sv | 84 ++++++++
 tb/tb_reg_file16_read.sv | 127 ++++++++++++
 2 files changed

// File: rtl/reg_file16_read.sv
// Eight-entry register file read side: two registered read ports with a one-cycle
// read strobe and same-cycle write-to-read forwarding. R0 always reads zero.
module reg_file16_read #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Write,
    input  logic [DEPTH_LOG2-1:0] WAddr,
    input  logic [WIDTH-1:0]      I,
    input  logic                  RdEn,
    input  logic [DEPTH_LOG2-1:0] RAddrA,
    input  logic [DEPTH_LOG2-1:0] RAddrB,
    output logic [WIDTH-1:0]      OA,
    output logic [WIDTH-1:0]      OB,
    output logic                  Valid,
    output logic                  dbg_state
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    // Handshake: RdEn is a request accepted unconditionally at the rising edge
    // (no backpressure); Valid is high for exactly the one cycle after each
    // accepted request, and OA/OB are only updated by an accepted request.
    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] val_a;
    logic [WIDTH-1:0] val_b;

    // A write landing this cycle on a read address supplies the new data.
    always_comb begin
        val_a = mem[RAddrA];
        if (Write && (WAddr == RAddrA)) begin
            val_a = I;
        end
        if (RAddrA == '0) begin
            val_a = '0;
        end
    end

    always_comb begin
        val_b = mem[RAddrB];
        if (Write && (WAddr == RAddrB)) begin
            val_b = I;
        end
        if (RAddrB == '0) begin
            val_b = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            OA    <= '0;
            OB    <= '0;
            Valid <= 1'b0;
            state <= IDLE;
        end else begin
            if (Write && (WAddr != '0)) begin
                mem[WAddr] <= I;
            end
            if (RdEn) begin
                OA    <= val_a;
                OB    <= val_b;
                Valid <= 1'b1;
                state <= DATA;
            end else begin
                Valid <= 1'b0;
                state <= IDLE;
            end
        end
    end

    assign dbg_state = (state == DATA);

endmodule

// File: tb/tb_reg_file16_read.sv
// Directed and randomized bench for reg_file16_read, checked against an
// array-based reference model of the register file and read rules.
module tb_reg_file16_read;

    localparam int W  = 16;
    localparam int AW = 3;

    logic          CLK;
    logic          Reset;
    logic          Write;
    logic [AW-1:0] WAddr;
    logic [W-1:0]  I;
    logic          RdEn;
    logic [AW-1:0] RAddrA;
    logic [AW-1:0] RAddrB;
    logic [W-1:0]  OA;
    logic [W-1:0]  OB;
    logic          Valid;
    logic          dbg_state;

    reg_file16_read #(.WIDTH(W), .DEPTH_LOG2(AW)) dut (
        .CLK(CLK), .Reset(Reset), .Write(Write), .WAddr(WAddr), .I(I),
        .RdEn(RdEn), .RAddrA(RAddrA), .RAddrB(RAddrB),
        .OA(OA), .OB(OB), .Valid(Valid), .dbg_state(dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // reference model and scoreboard
    logic [W-1:0]   model [8];
    logic [2*W-1:0] exp_q [$];
    logic [W-1:0]   exp_oa;
    logic [W-1:0]   exp_ob;
    logic           exp_v;
    int             checks;
    int             passed;

    function automatic logic [W-1:0] ref_value(input logic [AW-1:0] x,
                                               input logic wr,
                                               input logic [AW-1:0] wa,
                                               input logic [W-1:0] d);
        if (x == 0) return '0;
        if (wr && wa == x) return d;
        return model[x];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // driver: one clock cycle of stimulus, then compare against the model
    task automatic step(input logic rst, input logic wr, input logic [AW-1:0] wa,
                        input logic [W-1:0] d, input logic rd,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        @(negedge CLK);
        Reset = rst; Write = wr; WAddr = wa; I = d; RdEn = rd; RAddrA = ra; RAddrB = rb;
        if (rst) begin
            for (int k = 0; k < 8; k++) model[k] = '0;
            exp_q.delete();
            exp_oa = '0;
            exp_ob = '0;
            exp_v  = 1'b0;
        end else begin
            exp_v = rd;
            if (rd) exp_q.push_back({ref_value(ra, wr, wa, d), ref_value(rb, wr, wa, d)});
            if (wr && wa != 0) model[wa] = d;
        end
        @(posedge CLK);
        #1;
        if (exp_v && exp_q.size() > 0) {exp_oa, exp_ob} = exp_q.pop_front();
        check("valid", {15'd0, Valid}, {15'd0, exp_v});
        check("state", {15'd0, dbg_state}, {15'd0, exp_v});
        check("oa", OA, exp_oa);
        check("ob", OB, exp_ob);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        Reset = 1'b0; Write = 1'b0; WAddr = '0; I = '0; RdEn = 1'b0; RAddrA = '0; RAddrB = '0;
        for (int k = 0; k < 8; k++) model[k] = '0;
        exp_oa = '0; exp_ob = '0; exp_v = 1'b0;

        // reset then read
        step(1, 0, 0, 16'h0000, 0, 0, 0);
        step(1, 0, 0, 16'h0000, 0, 0, 0);
        step(0, 0, 0, 16'h0000, 1, 3, 7);
        // write then read, then hold
        step(0, 1, 2, 16'hBEEF, 0, 0, 0);
        step(0, 1, 5, 16'h1234, 0, 0, 0);
        step(0, 0, 0, 16'h0000, 1, 2, 5);
        step(0, 0, 0, 16'h0000, 0, 1, 1);
        // write after read must not disturb held outputs
        step(0, 1, 2, 16'h7777, 0, 2, 2);
        // R0 protection
        step(0, 1, 0, 16'hFFFF, 1, 0, 2);
        step(0, 0, 0, 16'h0000, 1, 0, 0);
        // forwarding
        step(0, 1, 4, 16'h1111, 0, 0, 0);
        step(0, 1, 4, 16'hAAAA, 1, 4, 4);
        step(0, 0, 0, 16'h0000, 1, 4, 3);
        // streaming reads
        for (int k = 1; k <= 4; k++) step(0, 1, AW'(k), W'(k), 0, 0, 0);
        for (int k = 1; k <= 4; k++) step(0, 0, 0, 16'h0000, 1, AW'(k), AW'(5 - k));
        step(0, 0, 0, 16'h0000, 0, 0, 0);
        // reset collisions
        step(0, 0, 0, 16'h0000, 1, 6, 2);
        step(1, 1, 6, 16'h5555, 1, 6, 6);
        step(0, 0, 0, 16'h0000, 1, 6, 4);

        // randomized traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), W'($urandom),
                 ($urandom_range(0, 3) != 0),
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
